router_sync: RTL and testbench

Parametrised output-side synchroniser for the packet router. Latches the destination address from the header, steers the write enable to one of `NUM_CH` output FIFOs and reports that FIFO's full status back to the input FSM. Drives `vld_out` per channel from FIFO empty flags. Fires a per-channel soft reset when a channel sits valid-but-unread for `TIMEOUT` consecutive cycles. Sits between the router FSM/register block and the output FIFO bank; generalises the fixed 3-channel synchroniser with a configurable channel count, a configurable timeout, invalid-address flagging and aborting the write on timeout.

---
 rtl/router_sync.sv | 108 ++++++++++
 tb/tb_router_sync.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/router_sync.sv
// router_sync: output-side synchroniser for the packet router.
// Latches the header destination, steers the FIFO write enable, reports the
// selected FIFO's full flag and raises a per-channel soft reset when a
// channel holds data that nobody reads for TIMEOUT consecutive cycles.
module router_sync #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] din,
    input  logic              detect_addr,
    input  logic              wr_en_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] rd_en,
    output logic [NUM_CH-1:0] wr_en,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_vld_q, addr_vld_d;
    logic              addr_err_q, addr_err_d;
    logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] sel;
    logic              din_in_range;
    logic              abort;

    // Decode the latched address into a one-hot channel select.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = (addr_q == ADDR_W'(i));
        end
    end

    assign din_in_range = ({1'b0, din} < NUM_CH_EXT);
    assign vld_out      = ~empty;
    assign wr_en        = (wr_en_reg && addr_vld_q) ? sel : '0;
    assign fifo_full    = addr_vld_q && (|(full & sel));
    assign soft_reset   = soft_reset_q;
    assign addr_err     = addr_err_q;

    // Per-channel unread-data timers; a pulse is issued and the count wraps
    // when the channel has been valid and unread for TIMEOUT cycles.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]        = '0;
            soft_reset_d[i] = 1'b0;
            if (vld_out[i] && !rd_en[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A timeout on the channel currently being written aborts the packet.
    assign abort = |(soft_reset_d & sel);

    // Address capture; a new header takes priority over an abort on the same edge.
    always_comb begin
        addr_d     = addr_q;
        addr_vld_d = addr_vld_q;
        addr_err_d = addr_err_q;
        if (detect_addr) begin
            addr_d     = din;
            addr_vld_d = din_in_range;
            addr_err_d = !din_in_range;
        end else if (addr_vld_q && abort) begin
            addr_vld_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            addr_vld_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            soft_reset_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            addr_q       <= addr_d;
            addr_vld_q   <= addr_vld_d;
            addr_err_q   <= addr_err_d;
            soft_reset_q <= soft_reset_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync with NUM_CH=3, ADDR_W=2, TIMEOUT=30.
module tb_router_sync;

    logic       clk;
    logic       rst;
    logic [1:0] din;
    logic       detect_addr;
    logic       wr_en_reg;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] rd_en;
    logic [2:0] wr_en;
    logic       fifo_full;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       addr_err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    router_sync #(
        .NUM_CH (3),
        .ADDR_W (2),
        .TIMEOUT(30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .detect_addr(detect_addr),
        .wr_en_reg  (wr_en_reg),
        .full       (full),
        .empty      (empty),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .fifo_full  (fifo_full),
        .vld_out    (vld_out),
        .soft_reset (soft_reset),
        .addr_err   (addr_err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] d, input logic det, input logic wreq,
                                 input logic [2:0] f, input logic [2:0] e, input logic [2:0] r);
        din         = d;
        detect_addr = det;
        wr_en_reg   = wreq;
        full        = f;
        empty       = e;
        rd_en       = r;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b0;
        applyStimulus(2'd2, 1'b1, 1'b1, 3'b100, 3'b010, 3'b000);
        #3;
        checkOutput("reset_wr_en", wr_en, 3'b000);
        checkOutput("reset_soft_reset", soft_reset, 3'b000);
        checkOutput("reset_addr_err", {2'b0, addr_err}, 3'b000);
        checkOutput("reset_vld_out", vld_out, 3'b101);
        checkOutput("reset_fifo_full", {2'b0, fifo_full}, 3'b000);
        tick();
        checkOutput("reset_ignores_detect", wr_en, 3'b000);
        rst = 1'b1;

        // Steering to channel 2, then channel 0, then channel 1.
        applyStimulus(2'd2, 1'b1, 1'b0, 3'b100, 3'b111, 3'b000);
        tick();
        applyStimulus(2'd2, 1'b0, 1'b1, 3'b100, 3'b111, 3'b000);
        #1;
        checkOutput("steer2_wr_en", wr_en, 3'b100);
        checkOutput("steer2_full", {2'b0, fifo_full}, 3'b001);
        full = 3'b011;
        #1;
        checkOutput("steer2_not_full", {2'b0, fifo_full}, 3'b000);
        wr_en_reg = 1'b0;
        #1;
        checkOutput("steer2_no_req", wr_en, 3'b000);
        applyStimulus(2'd0, 1'b1, 1'b1, 3'b100, 3'b111, 3'b000);
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("steer0_wr_en", wr_en, 3'b001);
        checkOutput("steer0_not_full", {2'b0, fifo_full}, 3'b000);
        full = 3'b001;
        #1;
        checkOutput("steer0_full", {2'b0, fifo_full}, 3'b001);
        applyStimulus(2'd1, 1'b1, 1'b1, 3'b000, 3'b001, 3'b000);
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("steer1_wr_en", wr_en, 3'b010);
        checkOutput("vld_out_comb", vld_out, 3'b110);

        // Invalid address 3.
        applyStimulus(2'd3, 1'b1, 1'b1, 3'b111, 3'b111, 3'b000);
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("bad_addr_err", {2'b0, addr_err}, 3'b001);
        checkOutput("bad_addr_wr_en", wr_en, 3'b000);
        checkOutput("bad_addr_full", {2'b0, fifo_full}, 3'b000);
        applyStimulus(2'd1, 1'b1, 1'b1, 3'b000, 3'b111, 3'b000);
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("readdr_err_clear", {2'b0, addr_err}, 3'b000);
        checkOutput("readdr_wr_en", wr_en, 3'b010);

        // Timeout on channel 1 with channel 0 latched (no abort involvement).
        applyStimulus(2'd0, 1'b1, 1'b0, 3'b000, 3'b111, 3'b000);
        tick();
        applyStimulus(2'd0, 1'b0, 1'b0, 3'b000, 3'b101, 3'b000);
        for (int k = 1; k <= 61; k++) begin
            tick();
            checkOutput($sformatf("timeout_cycle%0d", k + 1), soft_reset,
                        (k == 30 || k == 60) ? 3'b010 : 3'b000);
        end
        empty = 3'b111;
        tick();
        tick();

        // Read at cycle 29 restarts the count; pulse lands in cycle 60.
        empty = 3'b101;
        for (int c = 1; c <= 60; c++) begin
            rd_en = (c == 29) ? 3'b010 : 3'b000;
            tick();
            checkOutput($sformatf("rd_restart_cycle%0d", c + 1), soft_reset,
                        (c + 1 == 60) ? 3'b010 : 3'b000);
        end
        rd_en = 3'b000;
        empty = 3'b111;
        tick();
        tick();

        // Abort: channel 1 latched while it times out.
        applyStimulus(2'd1, 1'b1, 1'b1, 3'b000, 3'b101, 3'b000);
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("abort_start_wr_en", wr_en, 3'b010);
        for (int k = 0; k < 28; k++) tick();
        checkOutput("abort_pre_wr_en", wr_en, 3'b010);
        checkOutput("abort_pre_pulse", soft_reset, 3'b000);
        tick();
        checkOutput("abort_pulse", soft_reset, 3'b010);
        tick();
        checkOutput("abort_wr_en_off", wr_en, 3'b000);
        checkOutput("abort_pulse_done", soft_reset, 3'b000);
        checkOutput("abort_no_addr_err", {2'b0, addr_err}, 3'b000);

        // Re-latch; then detect_addr coinciding with the next pulse keeps writing.
        detect_addr = 1'b1;
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("relatch_wr_en", wr_en, 3'b010);
        for (int k = 0; k < 27; k++) tick();
        checkOutput("pre_pulse2_wr_en", wr_en, 3'b010);
        checkOutput("pre_pulse2_soft", soft_reset, 3'b000);
        detect_addr = 1'b1;
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("detect_wins_pulse", soft_reset, 3'b010);
        checkOutput("detect_wins_wr_en", wr_en, 3'b010);
        tick();
        checkOutput("detect_wins_after", wr_en, 3'b010);
        applyStimulus(2'd0, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
        tick();
        tick();

        // Asynchronous reset in cycle 20 of a count, with a packet in flight.
        applyStimulus(2'd2, 1'b1, 1'b1, 3'b000, 3'b101, 3'b000);
        tick();
        detect_addr = 1'b0;
        #1;
        checkOutput("midreset_pre_wr_en", wr_en, 3'b100);
        for (int k = 0; k < 18; k++) tick();
        rst = 1'b0;
        #2;
        checkOutput("midreset_wr_en", wr_en, 3'b000);
        checkOutput("midreset_soft", soft_reset, 3'b000);
        checkOutput("midreset_vld_out", vld_out, 3'b010);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("post_reset_wr_en", wr_en, 3'b000);
        for (int k = 1; k <= 31; k++) begin
            tick();
            checkOutput($sformatf("post_reset_cycle%0d", k + 1), soft_reset,
                        (k == 30) ? 3'b010 : 3'b000);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
